seq_alu: RTL and testbench
==========================

# seq_alu

Parametrised, handshaked multi-cycle ALU for the next-generation datapath. It keeps the existing 4-bit operation encoding for the single-cycle operations and adds iterative unsigned multiply, divide and remainder. Operands are accepted through a valid/ready input handshake, and the registered result is returned through a valid/ready output handshake. It sits between register read and writeback, and its stall output lets the controller hold the pipeline.

## Interface
- WIDTH, 32, operand/result width; power of two, 8..64
- CNT_W, $clog2(WIDTH)+1, iteration counter width; not overridden
- clk  input  1  clock; all state updates on the rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  op/a/b are valid
- in_ready  output  1  block can accept an operation
- op  input  4  operation code
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- out_valid  output  1  result/zero_flag are valid
- out_ready  input  1  consumer accepts the result
- result  output  WIDTH  operation result
- zero_flag  output  1  1 when result == 0
- busy  output  1  operation in flight (state != IDLE)

## Operation
- Opcodes: 0001 ADD, 0010 SUB, 0011 SHL_U, 0100 SHR_U, 0101 SHL_S, 0110 SHR_S (arithmetic), 0111 LT (unsigned, result 1/0), 1000 EQ, 1001 NEQ, 1010 AND, 1011 OR, 1100 XOR, 1101 NOR, 1110 MULU, 1111 DIVU, 0000 REMU.
- Arithmetic and shift rules:
  - ADD and SUB wrap modulo 2^WIDTH.
  - Shift amount is the full unsigned value of b. If b >= WIDTH, logical shifts and SHL_S give 0, and SHR_S gives WIDTH copies of a[WIDTH-1].
  - MULU returns the low WIDTH bits of the product.
- State machine: IDLE, MUL, DIV, DONE.
  - IDLE: in_ready=1. On in_valid, latch op/a/b.
    - Single-cycle ops compute and register the result, then go to DONE.
    - MULU loads the counter with WIDTH and goes to MUL.
    - DIVU/REMU with b != 0 load the counter with WIDTH and go to DIV.
    - DIVU/REMU with b == 0 go straight to DONE: quotient all ones, remainder = a.
  - MUL: shift-add, one multiplier bit per cycle. When the counter reaches 0, go to DONE.
  - DIV: restoring division, one quotient bit per cycle. When the counter reaches 0, go to DONE and select the quotient or remainder.
  - DONE: out_valid=1. result and zero_flag are held stable until out_ready=1, then go to IDLE.
- zero_flag is registered together with result, computed from the final result value.
- in_ready is 0 in every state except IDLE. Inputs presented while in_ready=0 are ignored, and op/a/b need not be held after acceptance.
- Async reset mid-operation abandons the operation immediately. No partial result is ever presented.

## Timing
- Reset values: state IDLE, in_ready=1, out_valid=0, result=0, zero_flag=0, busy=0, counter 0.
- Latency is measured from the accepting edge T (in_valid && in_ready):
  - Single-cycle ops and divide-by-zero: out_valid from T+1.
  - MULU, DIVU, REMU: out_valid from T+WIDTH+1.
- Output handshake completes at the first edge with out_valid && out_ready. out_valid=0 and in_ready=1 from that edge.
- Peak throughput is one single-cycle op per 2 cycles. There is no bypass from DONE to a new accept in the same cycle.
- out_ready held low keeps DONE indefinitely, with result and zero_flag unchanged.
- busy=1 exactly while state != IDLE.

## Configuration
- SEQ_ALU_DIV_EN defined: divider logic and the DIV state are present, and DIVU/REMU behave as specified.
- SEQ_ALU_DIV_EN undefined: the divider and DIV state are removed. Opcodes 1111 and 0000 complete as single-cycle ops with result 0 and zero_flag 1. MULU is unaffected.

## Test plan
- Reset and basic ops:
  - Stimulus: reset, then ADD a=0xFFFFFFFF, b=1 with out_ready=1.
  - Response: out_valid one cycle after accept, result=0, zero_flag=1. All outputs were at reset values during reset.
- Shifts:
  - Stimulus: SHR_S a=0x80000000, b=4, then b=40; SHL_U a=1, b=31.
  - Response: 0xF8000000, then 0xFFFFFFFF, then 0x80000000.
- Multiply:
  - Stimulus: MULU a=0x00010001, b=0x00010001.
  - Response: result 0x00020001, out_valid exactly 33 cycles after accept, busy=1 throughout.
- Divide (SEQ_ALU_DIV_EN defined):
  - DIVU 100/7 -> 14 after 33 cycles.
  - REMU 100/7 -> 2 after 33 cycles.
  - DIVU 5/0 -> 0xFFFFFFFF after 1 cycle.
  - REMU 5/0 -> 5 after 1 cycle.
- Backpressure:
  - Stimulus: SUB 3-3 with out_ready=0 for 10 cycles while in_valid stays asserted with new ops.
  - Response: result=0 and zero_flag=1 held, in_ready=0, no new op accepted. After out_ready=1, in_ready=1 next cycle.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 during cycle 10 of a MULU.
  - Response: out_valid=0, in_ready=1 and busy=0 immediately. A following AND 0xF0F0/0x0FF0 yields 0x00F0.

Source files
------------

// File: rtl/seq_alu.sv
// ============================================================================
//  seq_alu : handshaked multi-cycle ALU with single-cycle logic/arith ops,
//            iterative unsigned multiply and optional restoring divide.
//  Optional feature macro: SEQ_ALU_DIV_EN (divider + DIV state present)
//  Revision: 1.0
// ============================================================================
`default_nettype none

module seq_alu #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero_flag,
    output logic             busy
);

    localparam int SHW = $clog2(WIDTH);

    localparam logic [3:0] c_OP_REMU  = 4'b0000;
    localparam logic [3:0] c_OP_ADD   = 4'b0001;
    localparam logic [3:0] c_OP_SUB   = 4'b0010;
    localparam logic [3:0] c_OP_SHL_U = 4'b0011;
    localparam logic [3:0] c_OP_SHR_U = 4'b0100;
    localparam logic [3:0] c_OP_SHL_S = 4'b0101;
    localparam logic [3:0] c_OP_SHR_S = 4'b0110;
    localparam logic [3:0] c_OP_LT    = 4'b0111;
    localparam logic [3:0] c_OP_EQ    = 4'b1000;
    localparam logic [3:0] c_OP_NEQ   = 4'b1001;
    localparam logic [3:0] c_OP_AND   = 4'b1010;
    localparam logic [3:0] c_OP_OR    = 4'b1011;
    localparam logic [3:0] c_OP_XOR   = 4'b1100;
    localparam logic [3:0] c_OP_NOR   = 4'b1101;
    localparam logic [3:0] c_OP_MULU  = 4'b1110;
    localparam logic [3:0] c_OP_DIVU  = 4'b1111;

    localparam logic [WIDTH-1:0] c_WVAL     = WIDTH'(WIDTH);
    localparam logic [CNT_W-1:0] c_CNT_LOAD = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
`ifdef SEQ_ALU_DIV_EN
        ,S_DIV = 2'd3
`endif
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_x;
    logic [WIDTH-1:0] r_y;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;

    logic [WIDTH-1:0] w_alu;
    logic             w_big;
    logic [SHW-1:0]   w_sh;
    logic [WIDTH-1:0] w_mul_acc;

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);
    assign result    = r_result;
    assign zero_flag = r_zero;

    // Shift amounts at or beyond WIDTH saturate instead of wrapping the index.
    assign w_big = (b >= c_WVAL);
    assign w_sh  = b[SHW-1:0];

    always_comb begin
        w_alu = '0;
        case (op)
            c_OP_ADD:              w_alu = a + b;
            c_OP_SUB:              w_alu = a - b;
            c_OP_SHL_U, c_OP_SHL_S: w_alu = w_big ? '0 : (a << w_sh);
            c_OP_SHR_U:            w_alu = w_big ? '0 : (a >> w_sh);
            c_OP_SHR_S:            w_alu = w_big ? {WIDTH{a[WIDTH-1]}}
                                                 : WIDTH'($signed(a) >>> w_sh);
            c_OP_LT:               w_alu = {{(WIDTH-1){1'b0}}, (a < b)};
            c_OP_EQ:               w_alu = {{(WIDTH-1){1'b0}}, (a == b)};
            c_OP_NEQ:              w_alu = {{(WIDTH-1){1'b0}}, (a != b)};
            c_OP_AND:              w_alu = a & b;
            c_OP_OR:               w_alu = a | b;
            c_OP_XOR:              w_alu = a ^ b;
            c_OP_NOR:              w_alu = ~(a | b);
            default:               w_alu = '0;
        endcase
    end

    // Multiplicand shifts left in r_x, multiplier shifts right in r_y.
    assign w_mul_acc = r_acc + (r_y[0] ? r_x : '0);

`ifdef SEQ_ALU_DIV_EN
    logic             r_is_rem;
    logic [WIDTH:0]   w_div_shift;
    logic [WIDTH:0]   w_div_sub;
    logic             w_div_ok;
    logic [WIDTH-1:0] w_rem_next;
    logic [WIDTH-1:0] w_quo_next;

    // r_x holds the dividend shifting out on top and quotient bits filling in below.
    assign w_div_shift = {r_acc, r_x[WIDTH-1]};
    assign w_div_sub   = w_div_shift - {1'b0, r_y};
    assign w_div_ok    = ~w_div_sub[WIDTH];
    assign w_rem_next  = w_div_ok ? w_div_sub[WIDTH-1:0] : w_div_shift[WIDTH-1:0];
    assign w_quo_next  = {r_x[WIDTH-2:0], w_div_ok};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_x      <= '0;
            r_y      <= '0;
            r_acc    <= '0;
            r_result <= '0;
            r_zero   <= 1'b0;
`ifdef SEQ_ALU_DIV_EN
            r_is_rem <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        if (op == c_OP_MULU) begin
                            r_x     <= a;
                            r_y     <= b;
                            r_acc   <= '0;
                            r_cnt   <= c_CNT_LOAD;
                            r_state <= S_MUL;
`ifdef SEQ_ALU_DIV_EN
                        end else if ((op == c_OP_DIVU) || (op == c_OP_REMU)) begin
                            r_is_rem <= (op == c_OP_REMU);
                            if (b == '0) begin
                                r_result <= (op == c_OP_DIVU) ? '1 : a;
                                r_zero   <= (op == c_OP_REMU) && (a == '0);
                                r_state  <= S_DONE;
                            end else begin
                                r_x     <= a;
                                r_y     <= b;
                                r_acc   <= '0;
                                r_cnt   <= c_CNT_LOAD;
                                r_state <= S_DIV;
                            end
`endif
                        end else begin
                            r_result <= w_alu;
                            r_zero   <= (w_alu == '0);
                            r_state  <= S_DONE;
                        end
                    end
                end
                S_MUL: begin
                    r_acc <= w_mul_acc;
                    r_x   <= r_x << 1;
                    r_y   <= r_y >> 1;
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == c_CNT_LAST) begin
                        r_result <= w_mul_acc;
                        r_zero   <= (w_mul_acc == '0);
                        r_state  <= S_DONE;
                    end
                end
`ifdef SEQ_ALU_DIV_EN
                S_DIV: begin
                    r_acc <= w_rem_next;
                    r_x   <= w_quo_next;
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == c_CNT_LAST) begin
                        r_result <= r_is_rem ? w_rem_next : w_quo_next;
                        r_zero   <= r_is_rem ? (w_rem_next == '0) : (w_quo_next == '0);
                        r_state  <= S_DONE;
                    end
                end
`endif
                S_DONE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_seq_alu.sv
// ============================================================================
//  tb_seq_alu : randomized + directed self-checking bench for seq_alu
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_seq_alu;

    localparam int W = 32;
`ifdef SEQ_ALU_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [3:0]   op = 4'd0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] result;
    logic         zero_flag;
    logic         busy;

    seq_alu #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero_flag(zero_flag), .busy(busy)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_pass   = 0;
    bit         cmp_en   = 1'b0;
    logic [W-1:0] q_res[$];
    logic         q_zero[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference results straight from the arithmetic definition of each opcode.
    function automatic logic [W-1:0] model(input logic [3:0] o, input logic [W-1:0] x,
                                           input logic [W-1:0] y);
        logic [63:0] p;
        logic        big;
        big = (y >= 32'(W));
        case (o)
            4'd1:        return x + y;
            4'd2:        return x - y;
            4'd3, 4'd5:  return big ? '0 : (x << y);
            4'd4:        return big ? '0 : (x >> y);
            4'd6:        return big ? {W{x[W-1]}} : W'($signed(x) >>> y);
            4'd7:        return W'(x < y);
            4'd8:        return W'(x == y);
            4'd9:        return W'(x != y);
            4'd10:       return x & y;
            4'd11:       return x | y;
            4'd12:       return x ^ y;
            4'd13:       return ~(x | y);
            4'd14: begin
                p = 64'(x) * 64'(y);
                return p[W-1:0];
            end
            4'd15:       return !DIV_EN ? '0 : (y == 0) ? '1 : x / y;
            default:     return !DIV_EN ? '0 : (y == 0) ? x  : x % y;
        endcase
    endfunction

    function automatic int latency(input logic [3:0] o, input logic [W-1:0] y);
        if (o == 4'd14) return W + 1;
        if (DIV_EN && (o == 4'd15 || o == 4'd0) && y != 0) return W + 1;
        return 1;
    endfunction

    always @(negedge clk) begin
        if (cmp_en && rst_n) begin
            chk("busy_vs_in_ready", 64'(busy), 64'(!in_ready));
            if (out_valid) begin
                if (q_res.size() == 0) begin
                    chk("spurious_out_valid", 64'(out_valid), 64'(0));
                end else begin
                    chk("result", 64'(result), 64'(q_res[0]));
                    chk("zero_flag", 64'(zero_flag), 64'(q_zero[0]));
                end
            end
        end
    end

    always @(posedge clk) begin
        if (rst_n && out_valid && out_ready && q_res.size() > 0) begin
            void'(q_res.pop_front());
            void'(q_zero.pop_front());
        end
    end

    task automatic junk();
        in_valid = 1'b1;
        op = 4'($urandom);
        a  = $urandom;
        b  = $urandom;
    endtask

    task automatic do_op(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input int stall, output logic [W-1:0] res);
        int lat;
        logic [W-1:0] e;
        @(negedge clk);
        chk("in_ready_idle", 64'(in_ready), 64'(1));
        op = o; a = x; b = y; in_valid = 1'b1; out_ready = 1'b0;
        e = model(o, x, y);
        q_res.push_back(e);
        q_zero.push_back(e == '0);
        @(negedge clk);
        lat = 1;
        junk();
        chk("busy_inflight", 64'(busy), 64'(1));
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
            junk();
            chk("busy_inflight", 64'(busy), 64'(1));
        end
        chk("latency", 64'(lat), 64'(latency(o, y)));
        res = result;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            junk();
            chk("in_ready_held_low", 64'(in_ready), 64'(0));
            chk("result_held", 64'(result), 64'(res));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("out_valid_after_hs", 64'(out_valid), 64'(0));
        chk("in_ready_after_hs", 64'(in_ready), 64'(1));
        out_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] r;
        logic [3:0]   ro;
        logic [W-1:0] ra, rb;

        repeat (3) @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_result", 64'(result), 64'(0));
        chk("rst_zero", 64'(zero_flag), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        rst_n = 1'b1;
        cmp_en = 1'b1;

        do_op(4'd1, 32'hFFFF_FFFF, 32'd1, 0, r);
        chk("add_wrap", 64'(r), 64'h0);
        do_op(4'd6, 32'h8000_0000, 32'd4, 1, r);
        chk("shr_s_4", 64'(r), 64'hF800_0000);
        do_op(4'd6, 32'h8000_0000, 32'd40, 0, r);
        chk("shr_s_40", 64'(r), 64'hFFFF_FFFF);
        do_op(4'd3, 32'd1, 32'd31, 0, r);
        chk("shl_u_31", 64'(r), 64'h8000_0000);
        do_op(4'd14, 32'h0001_0001, 32'h0001_0001, 0, r);
        chk("mulu", 64'(r), 64'h0002_0001);
        do_op(4'd15, 32'd100, 32'd7, 0, r);
        chk("divu_100_7", 64'(r), DIV_EN ? 64'd14 : 64'd0);
        do_op(4'd0, 32'd100, 32'd7, 0, r);
        chk("remu_100_7", 64'(r), DIV_EN ? 64'd2 : 64'd0);
        do_op(4'd15, 32'd5, 32'd0, 0, r);
        chk("divu_5_0", 64'(r), DIV_EN ? 64'hFFFF_FFFF : 64'd0);
        do_op(4'd0, 32'd5, 32'd0, 0, r);
        chk("remu_5_0", 64'(r), DIV_EN ? 64'd5 : 64'd0);
        do_op(4'd2, 32'd3, 32'd3, 10, r);
        chk("sub_backpressure", 64'(r), 64'h0);

        // Abandon a multiply part-way through with an asynchronous reset.
        @(negedge clk);
        op = 4'd14; a = $urandom; b = $urandom; in_valid = 1'b1;
        q_res.push_back(model(op, a, b));
        q_zero.push_back(model(op, a, b) == '0);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        #2;
        rst_n = 1'b0;
        q_res.delete();
        q_zero.delete();
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'(0));
        chk("midrst_in_ready", 64'(in_ready), 64'(1));
        chk("midrst_busy", 64'(busy), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        do_op(4'd10, 32'h0000_F0F0, 32'h0000_0FF0, 0, r);
        chk("and_after_rst", 64'(r), 64'h0000_00F0);

        for (int i = 0; i < 80; i++) begin
            ro = 4'($urandom);
            ra = $urandom;
            case ($urandom_range(0, 7))
                0:       rb = '0;
                1, 2:    rb = $urandom_range(0, 40);
                3:       rb = $urandom_range(1, 255);
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 3) == 0) rb = ra;
            do_op(ro, ra, rb, $urandom_range(0, 3), r);
        end

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
